// File: rtl/renode_axi_burst_addr_gen.sv
// AXI burst address generator: turns one burst command into per-beat addresses, indices and responses.
// Optional build macro RENODE_AXI_4K_BOUNDARY_CHECK_EN flags incrementing bursts that cross a 4 KiB page.
module renode_axi_burst_addr_gen #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [AddressWidth-1:0] cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output logic [AddressWidth-1:0] beat_addr,
  output logic [7:0]              beat_index,
  output logic                    beat_last,
  output logic [1:0]              beat_resp
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  typedef enum logic [1:0] {
    BURST_FIXED    = 2'b00,
    BURST_INCR     = 2'b01,
    BURST_WRAP     = 2'b10,
    BURST_RESERVED = 2'b11
  } burst_type_e;

  localparam logic [2:0] MaxSize    = 3'($clog2(DataWidth / 8));
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  state_t state, next_state;

  logic                    cmd_fire;
  logic                    beat_fire;
  logic [AddressWidth-1:0] step_cmd;
  logic [AddressWidth-1:0] beats_cmd;
  logic [AddressWidth-1:0] total_cmd;
  logic [AddressWidth-1:0] wrap_lower_cmd;
  logic                    wrap_len_ok;
  logic                    cmd_err;

  logic [AddressWidth-1:0] step_q;
  logic [AddressWidth-1:0] wrap_lower_q;
  logic [AddressWidth-1:0] wrap_end_q;
  logic [7:0]              len_q;
  burst_type_e             burst_q;
  logic                    err_q;
  logic [AddressWidth-1:0] next_addr;
  logic [AddressWidth-1:0] wrap_sum;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign beat_fire = beat_valid && beat_ready;

  assign step_cmd       = AddressWidth'(1) << cmd_size;
  assign beats_cmd      = AddressWidth'(cmd_len) + AddressWidth'(1);
  assign total_cmd      = beats_cmd << cmd_size;
  assign wrap_lower_cmd = cmd_addr & ~(total_cmd - AddressWidth'(1));
  assign wrap_len_ok    = cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15};

`ifdef RENODE_AXI_4K_BOUNDARY_CHECK_EN
  logic [AddressWidth-1:0] aligned_cmd;
  logic [AddressWidth-1:0] last_byte_cmd;
  logic                    cross_4k;

  // Page check spans from the size-aligned start to the last byte of the final beat.
  assign aligned_cmd   = cmd_addr & ~(step_cmd - AddressWidth'(1));
  assign last_byte_cmd = aligned_cmd + total_cmd - AddressWidth'(1);
  assign cross_4k      = (cmd_burst == BURST_INCR) &&
                         (aligned_cmd[AddressWidth-1:12] != last_byte_cmd[AddressWidth-1:12]);
`else
  logic cross_4k;
  assign cross_4k = 1'b0;
`endif

  assign cmd_err = (cmd_burst == BURST_RESERVED) ||
                   (cmd_size > MaxSize) ||
                   ((cmd_burst == BURST_WRAP) && !wrap_len_ok) ||
                   cross_4k;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    beat_valid = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = BURST;
      end
      BURST: begin
        beat_valid = 1'b1;
        if (beat_ready && beat_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Errored bursts hold the start address for every beat.
  assign wrap_sum = beat_addr + step_q;

  always_comb begin
    next_addr = beat_addr;
    if (!err_q) begin
      unique case (burst_q)
        BURST_INCR: next_addr = (beat_addr & ~(step_q - AddressWidth'(1))) + step_q;
        BURST_WRAP: next_addr = (wrap_sum == wrap_end_q) ? wrap_lower_q : wrap_sum;
        default:    next_addr = beat_addr;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_addr    <= '0;
      beat_index   <= '0;
      beat_last    <= 1'b0;
      beat_resp    <= RespOkay;
      step_q       <= '0;
      wrap_lower_q <= '0;
      wrap_end_q   <= '0;
      len_q        <= '0;
      burst_q      <= BURST_FIXED;
      err_q        <= 1'b0;
    end else if (cmd_fire) begin
      beat_addr    <= cmd_addr;
      beat_index   <= 8'd0;
      beat_last    <= (cmd_len == 8'd0);
      beat_resp    <= cmd_err ? RespSlverr : RespOkay;
      step_q       <= step_cmd;
      wrap_lower_q <= wrap_lower_cmd;
      wrap_end_q   <= wrap_lower_cmd + total_cmd;
      len_q        <= cmd_len;
      burst_q      <= burst_type_e'(cmd_burst);
      err_q        <= cmd_err;
    end else if (beat_fire && !beat_last) begin
      beat_addr  <= next_addr;
      beat_index <= beat_index + 8'd1;
      beat_last  <= ((beat_index + 8'd1) == len_q);
    end
  end

endmodule

// File: tb/tb_renode_axi_burst_addr_gen.sv
// Self-checking bench for renode_axi_burst_addr_gen: vector table driven through a beat scoreboard,
// plus hand-written reset-mid-burst sequence. Expectations follow RENODE_AXI_4K_BOUNDARY_CHECK_EN.
module tb_renode_axi_burst_addr_gen;

  localparam logic [1:0] BFixed = 2'b00;
  localparam logic [1:0] BIncr  = 2'b01;
  localparam logic [1:0] BWrap  = 2'b10;
  localparam logic [1:0] BRsvd  = 2'b11;

  typedef struct packed {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [1:0]       mode;   // 0: ready always, 1: ready toggles 1/0, 2: random ready
    logic [1:0]       resp;
    logic [7:0][31:0] addrs;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  idx;
    logic        last;
    logic [1:0]  resp;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_burst = '0;
  logic        beat_valid;
  logic        beat_ready = 1'b0;
  logic [31:0] beat_addr;
  logic [7:0]  beat_index;
  logic        beat_last;
  logic [1:0]  beat_resp;

  int n_checks = 0;
  int n_fail   = 0;
  beat_t exp_q[$];
  vec_t  vecs[11];

  renode_axi_burst_addr_gen #(.AddressWidth(32), .DataWidth(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_index(beat_index), .beat_last(beat_last), .beat_resp(beat_resp)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [1:0] mode, input logic [1:0] resp,
                              input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] a3, input logic [31:0] a4, input logic [31:0] a5,
                              input logic [31:0] a6, input logic [31:0] a7);
    vec_t v;
    v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.mode = mode; v.resp = resp;
    v.addrs[0] = a0; v.addrs[1] = a1; v.addrs[2] = a2; v.addrs[3] = a3;
    v.addrs[4] = a4; v.addrs[5] = a5; v.addrs[6] = a6; v.addrs[7] = a7;
    return v;
  endfunction

  function automatic beat_t cur_beat();
    beat_t b;
    b = {beat_addr, beat_index, beat_last, beat_resp};
    return b;
  endfunction

  task automatic run_vec(input vec_t v, input int vi);
    int    guard;
    int    cyc;
    bit    done;
    bit    stalled;
    bit    r;
    beat_t held;
    beat_t e;
    string tag;
    tag = $sformatf("vec%0d", vi);
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge aclk);
      guard++;
    end
    check({tag, " cmd_ready before issue"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    cmd_size  = v.size;
    cmd_burst = v.burst;
    for (int j = 0; j <= int'(v.len); j++) begin
      e.addr = v.addrs[j];
      e.idx  = 8'(j);
      e.last = (j == int'(v.len));
      e.resp = v.resp;
      exp_q.push_back(e);
    end
    @(negedge aclk);
    cmd_valid = 1'b0;
    check({tag, " first beat latency"}, 64'(beat_valid), 64'd1);
    cyc = 0; done = 0; stalled = 0; held = '0;
    while (!done && cyc < 200) begin
      if (stalled) check({tag, " stall stable"}, 64'(cur_beat()), 64'(held));
      check({tag, " beat_valid in burst"}, 64'(beat_valid), 64'd1);
      check({tag, " cmd_ready in burst"}, 64'(cmd_ready), 64'd0);
      case (v.mode)
        2'd0:    r = 1'b1;
        2'd1:    r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      beat_ready = r;
      if (beat_valid && r) begin
        if (exp_q.size() == 0) begin
          check({tag, " unexpected beat"}, 64'(beat_valid), 64'd0);
          done = 1;
        end else begin
          e = exp_q.pop_front();
          check({tag, " beat"}, 64'(cur_beat()), 64'(e));
          if (e.last) done = 1;
        end
        stalled = 0;
      end else begin
        stalled = beat_valid;
        held = cur_beat();
      end
      @(negedge aclk);
      cyc++;
    end
    beat_ready = 1'b0;
    check({tag, " burst completed in budget"}, 64'(done), 64'd1);
    check({tag, " beat_valid after last"}, 64'(beat_valid), 64'd0);
    check({tag, " cmd_ready after last"}, 64'(cmd_ready), 64'd1);
    check({tag, " scoreboard drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0]  = mk(32'h1002, 8'd3, 3'd2, BIncr, 2'd0, 2'b00,
                  32'h1002, 32'h1004, 32'h1008, 32'h100C, 0, 0, 0, 0);
    vecs[1]  = mk(32'h34, 8'd3, 3'd2, BWrap, 2'd0, 2'b00,
                  32'h34, 32'h38, 32'h3C, 32'h30, 0, 0, 0, 0);
    vecs[2]  = mk(32'h34, 8'd2, 3'd2, BWrap, 2'd0, 2'b10,
                  32'h34, 32'h34, 32'h34, 0, 0, 0, 0, 0);
    vecs[3]  = mk(32'h200, 8'd2, 3'd2, BFixed, 2'd1, 2'b00,
                  32'h200, 32'h200, 32'h200, 0, 0, 0, 0, 0);
`ifdef RENODE_AXI_4K_BOUNDARY_CHECK_EN
    vecs[4]  = mk(32'hFF8, 8'd3, 3'd2, BIncr, 2'd0, 2'b10,
                  32'hFF8, 32'hFF8, 32'hFF8, 32'hFF8, 0, 0, 0, 0);
`else
    vecs[4]  = mk(32'hFF8, 8'd3, 3'd2, BIncr, 2'd0, 2'b00,
                  32'hFF8, 32'hFFC, 32'h1000, 32'h1004, 0, 0, 0, 0);
`endif
    vecs[5]  = mk(32'h40, 8'd0, 3'd2, BRsvd, 2'd0, 2'b10,
                  32'h40, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(32'h100, 8'd1, 3'd3, BIncr, 2'd2, 2'b10,
                  32'h100, 32'h100, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(32'h7, 8'd0, 3'd0, BIncr, 2'd0, 2'b00,
                  32'h7, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(32'hFFFF_FFFC, 8'd1, 3'd2, BIncr, 2'd0, 2'b00,
                  32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(32'hA, 8'd7, 3'd1, BWrap, 2'd2, 2'b00,
                  32'hA, 32'hC, 32'hE, 32'h0, 32'h2, 32'h4, 32'h6, 32'h8);
    vecs[10] = mk(32'h13, 8'd2, 3'd1, BIncr, 2'd1, 2'b00,
                  32'h13, 32'h14, 32'h16, 0, 0, 0, 0, 0);

    #1;
    check("reset beat_valid", 64'(beat_valid), 64'd0);
    check("reset outputs", 64'(cur_beat()), 64'd0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("cmd_ready after reset", 64'(cmd_ready), 64'd1);
    check("beat_valid after reset", 64'(beat_valid), 64'd0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset in the middle of an 8-beat incrementing burst.
    cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_len = 8'd7; cmd_size = 3'd2; cmd_burst = BIncr;
    @(negedge aclk);
    cmd_valid = 1'b0;
    beat_ready = 1'b1;
    repeat (2) @(negedge aclk);
    check("pre-reset beat 2", 64'(cur_beat()), 64'({32'h108, 8'd2, 1'b0, 2'b00}));
    aresetn = 1'b0;
    #1;
    check("mid-burst reset beat_valid", 64'(beat_valid), 64'd0);
    check("mid-burst reset outputs", 64'(cur_beat()), 64'd0);
    beat_ready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    beat_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      check("no beat after reset", 64'(beat_valid), 64'd0);
    end
    beat_ready = 1'b0;
    run_vec(vecs[0], 11);
    run_vec(vecs[9], 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/renode_axi_burst_addr_gen.md
RENODE_AXI_BURST_ADDR_GEN -- requirements
Module: renode_axi_burst_addr_gen

Interface
REQ-001 SHALL have parameter AddressWidth, default 32, width of byte addresses.
REQ-002 SHALL have parameter DataWidth, default 32, bus data width in bits (power of two, 8..1024).
REQ-003 SHALL have port aclk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port aresetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  burst command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_addr  input  AddressWidth  burst start address.
REQ-008 SHALL have port cmd_len  input  8  beats minus one (burst_length_t).
REQ-009 SHALL have port cmd_size  input  3  log2 bytes per beat (burst_size_t).
REQ-010 SHALL have port cmd_burst  input  2  burst type (burst_type_e).
REQ-011 SHALL have port beat_valid  output  1  beat address valid.
REQ-012 SHALL have port beat_ready  input  1  consumer takes beat.
REQ-013 SHALL have port beat_addr  output  AddressWidth  address of current beat.
REQ-014 SHALL have port beat_index  output  8  zero-based beat number.
REQ-015 SHALL have port beat_last  output  1  high on final beat.
REQ-016 SHALL have port beat_resp  output  2  response for beat (response_e).

Function
REQ-017 SHALL implement states IDLE and BURST; cmd_ready=1 only in IDLE, beat_valid=1 only in BURST.
REQ-018 SHALL latch all cmd_* on cmd_valid&&cmd_ready and enter BURST; first beat visible the next cycle (latency 1).
REQ-019 SHALL advance beat on beat_valid&&beat_ready; beat_last&&handshake returns to IDLE; no new command accepted in the same cycle (one idle bubble).
REQ-020 SHALL hold beat_addr, beat_index, beat_last, beat_resp stable while beat_valid&&!beat_ready.
REQ-021 Fixed: every beat_addr equals cmd_addr.
REQ-022 Incrementing: beat 0 = cmd_addr; beat n = (cmd_addr aligned down to 2^cmd_size) + n*2^cmd_size.
REQ-023 Wrapping: total = (cmd_len+1)*2^cmd_size; lower = cmd_addr aligned down to total; beat 0 = cmd_addr; next = addr+2^cmd_size, replaced by lower when it equals lower+total.
REQ-024 Address arithmetic SHALL be modulo 2^AddressWidth (silent wrap at top of space).
REQ-025 beat_resp SHALL be Okay (2'b00) unless a command error applies, then SlaveError (2'b10) on every beat of that burst.
REQ-026 Command errors: cmd_burst=Reserved; 2^cmd_size > DataWidth/8; Wrapping with cmd_len not in {1,3,7,15}.
REQ-027 On command error beat_addr SHALL equal cmd_addr for all beats; beat count remains cmd_len+1.
REQ-028 cmd_len=0 SHALL produce exactly one beat with beat_last=1.

Reset
REQ-029 aresetn low SHALL immediately force IDLE, cmd_ready=1 after release, beat_valid=0, beat_addr=0, beat_index=0, beat_last=0, beat_resp=2'b00.
REQ-030 Reset mid-burst SHALL discard remaining beats; no beat issued after release until a new command.

Configuration
REQ-031 With RENODE_AXI_4K_BOUNDARY_CHECK_EN defined, an Incrementing burst whose bytes from aligned start to last beat end cross a 4 KiB boundary SHALL be a command error (REQ-025/027).
REQ-032 Without RENODE_AXI_4K_BOUNDARY_CHECK_EN, no 4 KiB check; such bursts generate addresses per REQ-022 with Okay.

Verification
REQ-033 Incr addr 0x1002, size 2, len 3, beat_ready=1 -> addrs 0x1002,0x1004,0x1008,0x100C; last on beat 3; resp 00.
REQ-034 Wrap addr 0x34, size 2, len 3 -> 0x34,0x38,0x3C,0x30; Wrap len 2 -> 3 beats at 0x34, resp 10.
REQ-035 Fixed addr 0x200, len 2, beat_ready toggling 1/0 -> three beats 0x200, outputs stable while stalled, cmd_ready low until one cycle after last handshake.
REQ-036 Incr addr 0xFF8, size 2, len 3 -> with macro: 4 beats at 0xFF8, resp 10; without: 0xFF8,0xFFC,0x1000,0x1004, resp 00.
REQ-037 Burst=Reserved, len 0 -> one beat, last=1, resp 10; size 3 with DataWidth 32 -> resp 10.
REQ-038 aresetn low at beat 2 of 8-beat Incr -> beat_valid=0 same cycle, all outputs reset, next command starts at beat_index 0.
